// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions used by the fetch stage: reset defaults, the NOP
// encoding and the fetch state encoding.
package inst_fetch_pkg;

  // Default PC loaded on reset (must be word-aligned)
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Default ROM word-address width: 32 words, so valid PCs lie below 128
  localparam int unsigned DEFAULT_ROM_AW = 5;

  // Instruction encoding used for an empty output stage
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Fetch state: RUN issues fetches, HALT stops issuing them
  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  // Force an address onto a word boundary by clearing its two low bits
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch unit: holds the PC, drives the ROM address, registers the
// returned instruction and hands it to decode over a valid/ready handshake.
// Supports redirect and halt, and keeps sticky misalign / out-of-range flags.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned ROM_AW   = DEFAULT_ROM_AW
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        misalign_err,
  output logic        oob_err
);

  // Any PC bit at or above this position means the fetch lies outside the ROM
  localparam int unsigned PC_LIMIT_SHIFT = ROM_AW + 2;

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_inst_q, if_inst_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic         if_valid_q, if_valid_d;
  fetch_state_e state_q, state_d;
  logic         misalign_err_q, misalign_err_d;
  logic         oob_err_q, oob_err_d;

  logic         accept;
  logic         fetch_oob;
  logic         redirect_misaligned;

  // Decide whether the stage takes a new instruction this cycle; a pending
  // halt request or a redirect both block the fetch.
  always_comb begin
    accept = (state_q == FETCH_RUN) && !halt_req && !redirect_valid &&
             (!if_valid_q || if_ready);
    fetch_oob           = (pc_q >> PC_LIMIT_SHIFT) != 32'd0;
    redirect_misaligned = redirect_pc[1:0] != 2'b00;
  end

  // Next-state logic: redirect overrides everything, otherwise track halt
  // and either load a new instruction, drain the held one, or stall.
  always_comb begin
    pc_d           = pc_q;
    if_inst_d      = if_inst_q;
    if_pc_d        = if_pc_q;
    if_valid_d     = if_valid_q;
    state_d        = state_q;
    misalign_err_d = misalign_err_q;
    oob_err_d      = oob_err_q;

    if (redirect_valid) begin
      pc_d       = word_align(redirect_pc);
      if_valid_d = 1'b0;
      state_d    = FETCH_RUN;
      if (redirect_misaligned) begin
        misalign_err_d = 1'b1;
      end
    end else begin
      if (state_q == FETCH_RUN && halt_req) begin
        state_d = FETCH_HALT;
      end else if (state_q == FETCH_HALT && !halt_req) begin
        state_d = FETCH_RUN;
      end

      if (accept) begin
        if_inst_d  = rom_inst;
        if_pc_d    = pc_q;
        if_valid_d = 1'b1;
        pc_d       = pc_q + 32'd4;
        if (fetch_oob) begin
          oob_err_d = 1'b1;
        end
      end else if (if_valid_q && if_ready) begin
        if_valid_d = 1'b0;
      end
    end
  end

  // All stage state, including the fetch state, updates on the clock edge
  // and returns to its reset values as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      if_inst_q      <= NOP_INST;
      if_pc_q        <= 32'd0;
      if_valid_q     <= 1'b0;
      state_q        <= FETCH_RUN;
      misalign_err_q <= 1'b0;
      oob_err_q      <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      if_inst_q      <= if_inst_d;
      if_pc_q        <= if_pc_d;
      if_valid_q     <= if_valid_d;
      state_q        <= state_d;
      misalign_err_q <= misalign_err_d;
      oob_err_q      <= oob_err_d;
    end
  end

  // Outputs come straight from registers so rom_addr has no input path
  always_comb begin
    rom_addr     = pc_q;
    if_valid     = if_valid_q;
    if_inst      = if_inst_q;
    if_pc        = if_pc_q;
    if_pc_plus4  = if_pc_q + 32'd4;
    misalign_err = misalign_err_q;
    oob_err      = oob_err_q;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: a 32-word combinational ROM, a queue-based
// reference model compared every cycle, directed scenarios with literal
// expectations, then a randomized phase.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned ROM_WORDS = 32;
  localparam longint unsigned PC_LIMIT = 4 * ROM_WORDS;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        misalign_err;
  logic        oob_err;

  logic [31:0] rom [ROM_WORDS];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  slot_t       m_out[$];
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_mis;
  bit          m_oob;

  inst_fetch #(
    .RESET_PC(RESET_PC),
    .ROM_AW  (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .misalign_err  (misalign_err),
    .oob_err       (oob_err)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Instruction ROM: combinational read indexed by address bits [6:2]
  assign rom_inst = rom[rom_addr[6:2]];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's inputs, then let exactly one rising edge pass
  task automatic applyStimulus(input bit rv, input logic [31:0] rpc,
                               input bit halt, input bit ready);
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = halt;
    if_ready       = ready;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_out.delete();
    m_pc     = RESET_PC;
    m_halted = 0;
    m_mis    = 0;
    m_oob    = 0;
  endtask

  // One clock of the fetch rules: redirect flushes and retargets; otherwise
  // decode may consume the held word, and a fetch happens when running, not
  // asked to halt, and the one-word slot is (or becomes) free.
  task automatic model_step();
    bit consumed;
    bit can_fetch;
    slot_t s;
    consumed = (m_out.size() != 0) && if_ready;
    if (redirect_valid) begin
      m_out.delete();
      m_pc     = redirect_pc - (redirect_pc % 4);
      m_halted = 0;
      if (redirect_pc % 4 != 0) m_mis = 1;
    end else begin
      can_fetch = !m_halted && !halt_req && (m_out.size() == 0 || consumed);
      if (consumed) m_out.delete(0);
      if (can_fetch) begin
        s.pc   = m_pc;
        s.inst = rom[(m_pc / 4) % ROM_WORDS];
        m_out.push_back(s);
        if (longint'(m_pc) >= PC_LIMIT) m_oob = 1;
        m_pc = m_pc + 4;
      end
      m_halted = halt_req;
    end
  endtask

  // Advance the model at each rising edge and compare the DUT shortly after
  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step();
    #1;
    checkOutput("rom_addr", rom_addr, m_pc);
    checkOutput("if_valid", {31'd0, if_valid}, {31'd0, m_out.size() != 0});
    if (m_out.size() != 0) begin
      checkOutput("if_pc", if_pc, m_out[0].pc);
      checkOutput("if_inst", if_inst, m_out[0].inst);
      checkOutput("if_pc_plus4", if_pc_plus4, m_out[0].pc + 32'd4);
    end
    checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    checkOutput("oob_err", {31'd0, oob_err}, {31'd0, m_oob});
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt_req       = 1'b0;
    if_ready       = 1'b0;
    rom[0] = 32'h0000_0000;
    rom[1] = 32'h3c02_5678;
    for (int i = 2; i < ROM_WORDS; i++) rom[i] = $urandom();
    model_reset();

    @(negedge clk);
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst rom_addr", rom_addr, RESET_PC);
    checkOutput("rst if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst if_pc_plus4", if_pc_plus4, 32'd4);
    checkOutput("rst misalign", {31'd0, misalign_err}, 32'd0);

    $display("[TB] reset and stream");
    rst = 1'b0;
    applyStimulus(0, 32'd0, 0, 1);
    checkOutput("c1 if_pc", if_pc, 32'h0);
    checkOutput("c1 if_inst", if_inst, 32'h0);
    checkOutput("c1 if_valid", {31'd0, if_valid}, 32'd1);
    applyStimulus(0, 32'd0, 0, 1);
    checkOutput("c2 if_pc", if_pc, 32'h4);
    checkOutput("c2 if_inst", if_inst, 32'h3c02_5678);
    checkOutput("c2 if_pc_plus4", if_pc_plus4, 32'h8);

    $display("[TB] stall");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'd0, 0, 0);
      checkOutput("stall if_pc", if_pc, 32'h4);
      checkOutput("stall if_inst", if_inst, 32'h3c02_5678);
      checkOutput("stall rom_addr", rom_addr, 32'h8);
    end
    applyStimulus(0, 32'd0, 0, 1);
    checkOutput("unstall if_pc", if_pc, 32'h8);
    checkOutput("unstall if_inst", if_inst, rom[2]);

    $display("[TB] redirect during stall");
    applyStimulus(0, 32'd0, 0, 0);
    applyStimulus(1, 32'h40, 0, 0);
    checkOutput("redir if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("redir rom_addr", rom_addr, 32'h40);
    applyStimulus(0, 32'd0, 0, 1);
    checkOutput("redir if_pc", if_pc, 32'h40);
    checkOutput("redir if_inst", if_inst, rom[16]);

    $display("[TB] misaligned redirect");
    applyStimulus(1, 32'h13, 0, 1);
    checkOutput("misal rom_addr", rom_addr, 32'h10);
    checkOutput("misal flag", {31'd0, misalign_err}, 32'd1);
    applyStimulus(0, 32'd0, 0, 1);
    checkOutput("misal if_pc", if_pc, 32'h10);

    $display("[TB] halt and collision");
    applyStimulus(0, 32'd0, 1, 0);
    checkOutput("halt held valid", {31'd0, if_valid}, 32'd1);
    checkOutput("halt rom_addr", rom_addr, 32'h14);
    applyStimulus(0, 32'd0, 1, 1);
    checkOutput("halt drained", {31'd0, if_valid}, 32'd0);
    applyStimulus(0, 32'd0, 1, 1);
    checkOutput("halt frozen pc", rom_addr, 32'h14);
    checkOutput("halt no fetch", {31'd0, if_valid}, 32'd0);
    applyStimulus(1, 32'h8, 1, 1);
    checkOutput("collide rom_addr", rom_addr, 32'h8);
    applyStimulus(0, 32'd0, 1, 1);
    checkOutput("collide halted", {31'd0, if_valid}, 32'd0);
    checkOutput("collide pc held", rom_addr, 32'h8);
    applyStimulus(0, 32'd0, 0, 1);
    checkOutput("resume no fetch", {31'd0, if_valid}, 32'd0);
    applyStimulus(0, 32'd0, 0, 1);
    checkOutput("resume if_pc", if_pc, 32'h8);

    $display("[TB] out of range and wrap");
    applyStimulus(1, 32'h80, 0, 1);
    checkOutput("oob before", {31'd0, oob_err}, 32'd0);
    applyStimulus(0, 32'd0, 0, 1);
    checkOutput("oob flag", {31'd0, oob_err}, 32'd1);
    checkOutput("oob if_inst", if_inst, 32'h0);
    applyStimulus(1, 32'hFFFF_FFFC, 0, 1);
    applyStimulus(0, 32'd0, 0, 1);
    checkOutput("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap if_pc_plus4", if_pc_plus4, 32'h0);
    checkOutput("wrap rom_addr", rom_addr, 32'h0);

    $display("[TB] async reset mid-stall");
    applyStimulus(0, 32'd0, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("async rom_addr", rom_addr, RESET_PC);
    checkOutput("async if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("async misalign", {31'd0, misalign_err}, 32'd0);
    checkOutput("async oob", {31'd0, oob_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 32'd0, 0, 1);
    checkOutput("post-rst if_pc", if_pc, RESET_PC);
    checkOutput("post-rst if_valid", {31'd0, if_valid}, 32'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      bit rv;
      rv  = ($urandom_range(0, 99) < 10);
      rpc = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 140));
      if ($urandom_range(0, 9) == 0) rpc = rpc & ~32'h3;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        applyStimulus(0, 32'd0, 0, 1);
        rst = 1'b0;
      end else begin
        applyStimulus(rv, rpc, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 70));
      end
    end

    applyStimulus(0, 32'd0, 0, 1);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
